writeback_unit: RTL and testbench

Write-side front end for the RISC-V integer register file. Collects results from the single-cycle ALU, the load unit and the multi-cycle divider, formats load data, and arbitrates them onto the register file's single write port, one write per cycle. Keeps a pending-write scoreboard so the issue stage can detect RAW/WAW hazards on long-latency destinations.

---
 rtl/writeback_unit.sv | 182 ++++++++++++++++++
 tb/tb_writeback_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Write-side front end of the integer register file: merges ALU, load and divider
// results onto one write port and tracks pending long-latency destinations.
module writeback_unit (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_AluValid,
  input  logic [4:0]  i_AluRd,
  input  logic [31:0] i_AluData,
  input  logic        i_LdValid,
  output logic        o_LdReady,
  input  logic [4:0]  i_LdRd,
  input  logic [2:0]  i_LdFunct3,
  input  logic [1:0]  i_LdByteOff,
  input  logic [31:0] i_LdWord,
  input  logic        i_DivValid,
  output logic        o_DivReady,
  input  logic [4:0]  i_DivRd,
  input  logic [31:0] i_DivData,
  input  logic        i_IssueValid,
  input  logic [4:0]  i_IssueRd,
  input  logic [4:0]  i_Rs1,
  input  logic [4:0]  i_Rs2,
  output logic        o_Busy1,
  output logic        o_Busy2,
  output logic        o_fWE,
  output logic [4:0]  o_Rd,
  output logic [31:0] o_Data
);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LD,
    SRC_DIV
  } src_e;

  function automatic logic [31:0] fmt_load(input logic [2:0]  funct3,
                                           input logic [1:0]  off,
                                           input logic [31:0] word);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] res;
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  res = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  res = {{16{half_sel[15]}}, half_sel};
      3'b100:  res = {24'd0, byte_sel};
      3'b101:  res = {16'd0, half_sel};
      default: res = word;
    endcase
    return res;
  endfunction

  logic        ld_vld_q, ld_vld_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        div_vld_q, div_vld_d;
  logic [4:0]  div_rd_q, div_rd_d;
  logic [31:0] div_data_q, div_data_d;
  logic        last_div_q, last_div_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        sb_wr_q, sb_wr_d;
  logic [31:0] busy_q, busy_d;

  src_e        src;
  logic        gnt_ld, gnt_div, ld_acc, div_acc;
  logic [4:0]  gnt_rd;
  logic [31:0] gnt_data;

  // Arbitration: ALU first, then round-robin between the two buffers.
  // NOTE: every always_comb output gets a default first so no latches are inferred.
  always_comb begin
    src = SRC_NONE;
    if (i_AluValid)              src = SRC_ALU;
    else if (ld_vld_q && div_vld_q) src = last_div_q ? SRC_LD : SRC_DIV;
    else if (ld_vld_q)           src = SRC_LD;
    else if (div_vld_q)          src = SRC_DIV;

    gnt_ld  = (src == SRC_LD);
    gnt_div = (src == SRC_DIV);

    gnt_rd   = 5'd0;
    gnt_data = 32'd0;
    case (src)
      SRC_ALU: begin gnt_rd = i_AluRd;  gnt_data = i_AluData;  end
      SRC_LD:  begin gnt_rd = ld_rd_q;  gnt_data = ld_data_q;  end
      SRC_DIV: begin gnt_rd = div_rd_q; gnt_data = div_data_q; end
      default: ;
    endcase
  end

  assign o_LdReady  = !ld_vld_q || gnt_ld;
  assign o_DivReady = !div_vld_q || gnt_div;
  assign ld_acc     = i_LdValid && o_LdReady;
  assign div_acc    = i_DivValid && o_DivReady;

  always_comb begin
    ld_vld_d  = ld_vld_q;
    ld_rd_d   = ld_rd_q;
    ld_data_d = ld_data_q;
    if (ld_acc) begin
      ld_vld_d  = 1'b1;
      ld_rd_d   = i_LdRd;
      ld_data_d = fmt_load(i_LdFunct3, i_LdByteOff, i_LdWord);
    end else if (gnt_ld) begin
      ld_vld_d  = 1'b0;
    end

    div_vld_d  = div_vld_q;
    div_rd_d   = div_rd_q;
    div_data_d = div_data_q;
    if (div_acc) begin
      div_vld_d  = 1'b1;
      div_rd_d   = i_DivRd;
      div_data_d = i_DivData;
    end else if (gnt_div) begin
      div_vld_d  = 1'b0;
    end

    last_div_d = last_div_q;
    if (gnt_ld)  last_div_d = 1'b0;
    if (gnt_div) last_div_d = 1'b1;

    // A grant to x0 is consumed silently; index/data still track the grant.
    we_d    = (src != SRC_NONE) && (gnt_rd != 5'd0);
    rd_d    = (src != SRC_NONE) ? gnt_rd : rd_q;
    data_d  = (src != SRC_NONE) ? gnt_data : data_q;
    sb_wr_d = we_d && (src != SRC_ALU);

    // Clear applies first so a same-edge issue to the same register wins.
    busy_d = busy_q;
    if (we_q && sb_wr_q) busy_d[rd_q] = 1'b0;
    if (i_IssueValid)    busy_d[i_IssueRd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      ld_vld_q   <= 1'b0;
      ld_rd_q    <= 5'd0;
      ld_data_q  <= 32'd0;
      div_vld_q  <= 1'b0;
      div_rd_q   <= 5'd0;
      div_data_q <= 32'd0;
      last_div_q <= 1'b1;
      we_q       <= 1'b0;
      rd_q       <= 5'd0;
      data_q     <= 32'd0;
      sb_wr_q    <= 1'b0;
      busy_q     <= 32'd0;
    end else begin
      ld_vld_q   <= ld_vld_d;
      ld_rd_q    <= ld_rd_d;
      ld_data_q  <= ld_data_d;
      div_vld_q  <= div_vld_d;
      div_rd_q   <= div_rd_d;
      div_data_q <= div_data_d;
      last_div_q <= last_div_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      sb_wr_q    <= sb_wr_d;
      busy_q     <= busy_d;
    end
  end

  assign o_fWE   = we_q;
  assign o_Rd    = rd_q;
  assign o_Data  = data_q;
  assign o_Busy1 = busy_q[i_Rs1];
  assign o_Busy2 = busy_q[i_Rs2];

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: reset, ALU path, load formatting, contention,
// scoreboard set/clear and x0 handling, with hand-computed expectations.
module tb_writeback_unit;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic        i_AluValid;
  logic [4:0]  i_AluRd;
  logic [31:0] i_AluData;
  logic        i_LdValid;
  logic        o_LdReady;
  logic [4:0]  i_LdRd;
  logic [2:0]  i_LdFunct3;
  logic [1:0]  i_LdByteOff;
  logic [31:0] i_LdWord;
  logic        i_DivValid;
  logic        o_DivReady;
  logic [4:0]  i_DivRd;
  logic [31:0] i_DivData;
  logic        i_IssueValid;
  logic [4:0]  i_IssueRd;
  logic [4:0]  i_Rs1, i_Rs2;
  logic        o_Busy1, o_Busy2;
  logic        o_fWE;
  logic [4:0]  o_Rd;
  logic [31:0] o_Data;

  int vectors = 0;
  int miscompares = 0;

  writeback_unit dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_AluValid(i_AluValid), .i_AluRd(i_AluRd), .i_AluData(i_AluData),
    .i_LdValid(i_LdValid), .o_LdReady(o_LdReady), .i_LdRd(i_LdRd),
    .i_LdFunct3(i_LdFunct3), .i_LdByteOff(i_LdByteOff), .i_LdWord(i_LdWord),
    .i_DivValid(i_DivValid), .o_DivReady(o_DivReady), .i_DivRd(i_DivRd),
    .i_DivData(i_DivData),
    .i_IssueValid(i_IssueValid), .i_IssueRd(i_IssueRd),
    .i_Rs1(i_Rs1), .i_Rs2(i_Rs2), .o_Busy1(o_Busy1), .o_Busy2(o_Busy2),
    .o_fWE(o_fWE), .o_Rd(o_Rd), .o_Data(o_Data)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [4:0] rd,
                          input logic [31:0] data);
    check({tag, ".we"}, {31'd0, o_fWE}, {31'd0, we});
    check({tag, ".rd"}, {27'd0, o_Rd}, {27'd0, rd});
    check({tag, ".data"}, o_Data, data);
  endtask

  task automatic drive_ld(input logic v, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] w);
    i_LdValid = v; i_LdRd = rd; i_LdFunct3 = f3; i_LdByteOff = off; i_LdWord = w;
  endtask

  initial begin
    // Reset with every valid asserted.
    i_Rst = 1'b1;
    i_AluValid = 1'b1; i_AluRd = 5'd9; i_AluData = 32'h1111_1111;
    drive_ld(1'b1, 5'd8, 3'b010, 2'd0, 32'h2222_2222);
    i_DivValid = 1'b1; i_DivRd = 5'd6; i_DivData = 32'h3333_3333;
    i_IssueValid = 1'b1; i_IssueRd = 5'd7;
    i_Rs1 = 5'd7; i_Rs2 = 5'd8;
    step();
    step();
    i_Rst = 1'b0; i_AluValid = 1'b0; i_LdValid = 1'b0; i_DivValid = 1'b0; i_IssueValid = 1'b0;
    #1;
    check_wr("reset", 1'b0, 5'd0, 32'd0);
    check("reset.busy1", {31'd0, o_Busy1}, 32'd0);
    check("reset.busy2", {31'd0, o_Busy2}, 32'd0);
    check("reset.ldready", {31'd0, o_LdReady}, 32'd1);
    check("reset.divready", {31'd0, o_DivReady}, 32'd1);
    step();
    check_wr("reset.idle", 1'b0, 5'd0, 32'd0);

    // ALU write appears exactly one cycle later.
    i_AluValid = 1'b1; i_AluRd = 5'd5; i_AluData = 32'hDEAD_BEEF;
    step();
    i_AluValid = 1'b0;
    check_wr("alu", 1'b1, 5'd5, 32'hDEAD_BEEF);
    step();
    check_wr("alu.after", 1'b0, 5'd5, 32'hDEAD_BEEF);

    // Load formatting, one load at a time (write lands two edges after handshake).
    drive_ld(1'b1, 5'd9, 3'b000, 2'd0, 32'h8070_F0A5);
    check("lb.ready", {31'd0, o_LdReady}, 32'd1);
    step(); i_LdValid = 1'b0;
    check("lb.notyet", {31'd0, o_fWE}, 32'd0);
    step(); check_wr("lb", 1'b1, 5'd9, 32'hFFFF_FFA5);
    drive_ld(1'b1, 5'd9, 3'b100, 2'd1, 32'h8070_F0A5);
    step(); i_LdValid = 1'b0;
    step(); check_wr("lbu", 1'b1, 5'd9, 32'h0000_00F0);
    drive_ld(1'b1, 5'd9, 3'b001, 2'd2, 32'h8070_F0A5);
    step(); i_LdValid = 1'b0;
    step(); check_wr("lh", 1'b1, 5'd9, 32'hFFFF_8070);
    drive_ld(1'b1, 5'd9, 3'b101, 2'd0, 32'h8070_F0A5);
    step(); i_LdValid = 1'b0;
    step(); check_wr("lhu", 1'b1, 5'd9, 32'h0000_F0A5);
    drive_ld(1'b1, 5'd9, 3'b010, 2'd3, 32'h8070_F0A5);
    step(); i_LdValid = 1'b0;
    step(); check_wr("lw", 1'b1, 5'd9, 32'h8070_F0A5);
    drive_ld(1'b1, 5'd9, 3'b111, 2'd1, 32'h8070_F0A5);
    step(); i_LdValid = 1'b0;
    step(); check_wr("f3_other", 1'b1, 5'd9, 32'h8070_F0A5);

    // Back-to-back loads: one write per cycle.
    drive_ld(1'b1, 5'd10, 3'b010, 2'd0, 32'd1);
    step();
    drive_ld(1'b1, 5'd11, 3'b010, 2'd0, 32'd2);
    check("stream.ready", {31'd0, o_LdReady}, 32'd1);
    step(); check_wr("stream0", 1'b1, 5'd10, 32'd1);
    drive_ld(1'b1, 5'd12, 3'b010, 2'd0, 32'd3);
    step(); check_wr("stream1", 1'b1, 5'd11, 32'd2);
    i_LdValid = 1'b0;
    step(); check_wr("stream2", 1'b1, 5'd12, 32'd3);

    // Lone divider result; leaves the round-robin pointer on the divider.
    i_DivValid = 1'b1; i_DivRd = 5'd13; i_DivData = 32'h0000_0D1F;
    step(); i_DivValid = 1'b0;
    step(); check_wr("div", 1'b1, 5'd13, 32'h0000_0D1F);

    // Contention: both buffers fill, ALU holds the port for three cycles.
    drive_ld(1'b1, 5'd3, 3'b010, 2'd0, 32'hAAAA_0003);
    i_DivValid = 1'b1; i_DivRd = 5'd4; i_DivData = 32'hBBBB_0004;
    step();
    i_LdValid = 1'b0; i_DivValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_AluValid = 1'b1; i_AluRd = 5'(20 + k); i_AluData = 32'hC000_0000 + k;
      #1;
      check($sformatf("cont.ldready%0d", k), {31'd0, o_LdReady}, 32'd0);
      check($sformatf("cont.divready%0d", k), {31'd0, o_DivReady}, 32'd0);
      step();
      check_wr($sformatf("cont.alu%0d", k), 1'b1, 5'(20 + k), 32'hC000_0000 + k);
    end
    i_AluValid = 1'b0;
    #1;
    check("cont.ldgrant", {31'd0, o_LdReady}, 32'd1);
    check("cont.divwait", {31'd0, o_DivReady}, 32'd0);
    step(); check_wr("cont.ld", 1'b1, 5'd3, 32'hAAAA_0003);
    step(); check_wr("cont.div", 1'b1, 5'd4, 32'hBBBB_0004);
    step(); check("cont.drain", {31'd0, o_fWE}, 32'd0);

    // Scoreboard set, commit-clear, then same-edge set and clear.
    i_Rs1 = 5'd7; i_Rs2 = 5'd0;
    i_IssueValid = 1'b1; i_IssueRd = 5'd7;
    #1; check("sb.pre", {31'd0, o_Busy1}, 32'd0);
    step(); i_IssueValid = 1'b0;
    check("sb.set", {31'd0, o_Busy1}, 32'd1);
    drive_ld(1'b1, 5'd7, 3'b010, 2'd0, 32'h0000_0777);
    step(); i_LdValid = 1'b0;
    check("sb.buffered", {31'd0, o_Busy1}, 32'd1);
    step(); check_wr("sb.commit", 1'b1, 5'd7, 32'h0000_0777);
    check("sb.commitcycle", {31'd0, o_Busy1}, 32'd1);
    step(); check("sb.cleared", {31'd0, o_Busy1}, 32'd0);

    i_IssueValid = 1'b1; i_IssueRd = 5'd7;
    step(); i_IssueValid = 1'b0;
    check("sb.set2", {31'd0, o_Busy1}, 32'd1);
    drive_ld(1'b1, 5'd7, 3'b010, 2'd0, 32'h0000_0778);
    step(); i_LdValid = 1'b0;
    step(); check_wr("sb.commit2", 1'b1, 5'd7, 32'h0000_0778);
    i_IssueValid = 1'b1; i_IssueRd = 5'd7;
    step(); i_IssueValid = 1'b0;
    check("sb.samedge", {31'd0, o_Busy1}, 32'd1);
    step(); check("sb.samedge.hold", {31'd0, o_Busy1}, 32'd1);

    // ALU write to a busy register leaves it busy.
    i_AluValid = 1'b1; i_AluRd = 5'd7; i_AluData = 32'h0000_0A1A;
    step(); i_AluValid = 1'b0;
    step(); check("sb.aluwrite", {31'd0, o_Busy1}, 32'd1);

    // Writes to x0 are consumed but never enable the register file.
    i_IssueValid = 1'b1; i_IssueRd = 5'd0;
    drive_ld(1'b1, 5'd0, 3'b010, 2'd0, 32'h0BAD_0000);
    #1; check("x0.ready", {31'd0, o_LdReady}, 32'd1);
    step(); i_LdValid = 1'b0; i_IssueValid = 1'b0;
    check("x0.busy", {31'd0, o_Busy2}, 32'd0);
    check("x0.granted", {31'd0, o_LdReady}, 32'd1);
    step(); check("x0.we", {31'd0, o_fWE}, 32'd0);
    step(); check("x0.we2", {31'd0, o_fWE}, 32'd0);
    check("x0.busy2", {31'd0, o_Busy2}, 32'd0);

    // Reset mid-operation drops a buffered result.
    drive_ld(1'b1, 5'd15, 3'b010, 2'd0, 32'h0000_0F0F);
    step(); i_LdValid = 1'b0;
    i_Rst = 1'b1;
    step(); i_Rst = 1'b0;
    check_wr("midrst", 1'b0, 5'd0, 32'd0);
    check("midrst.busy1", {31'd0, o_Busy1}, 32'd0);
    step(); check("midrst.dropped", {31'd0, o_fWE}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
